matrix_stream_out: RTL and testbench
====================================

Name: matrix_stream_out

Overview:
- Downstream drain stage for one macc matrix port (A first; B/C reuse it).
- On `start`, issues exactly NWORDS single-cycle read enables to macc and captures each 1-cycle-latency BRAM word.
- Presents the words on a valid/ready output stream with `m_last` on the final word.
- Read issue is credit-limited, so no word is lost under backpressure.

Parameters:
- DATA_W, 32, stream/BRAM word width.
- NWORDS, 4096, words per matrix (64x64).
- CNT_W, 13, counter width; must hold the value NWORDS.

Ports:
- CLK  in  1  system clock, all logic rising-edge.
- RST_L  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request to stream one full matrix; ignored while busy=1.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  1-cycle pulse after the last word is accepted downstream.
- ren  out  1  read enable to macc; one pulse = one word on rd_data next cycle, with macc address auto-advancing.
- rd_data  in  DATA_W  macc matrix_x_out; valid exactly 1 cycle after ren.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept; transfer when m_valid & m_ready.
- m_data  out  DATA_W  output word.
- m_last  out  1  high with the NWORDS-th word only.

Behaviour:
Reset:
- All outputs are 0 and all counters and buffer are empty while RST_L=0. Reset is asynchronous and active-low.
- Reset mid-operation aborts immediately. No done pulse. Buffered data is discarded.
- macc address control shares RST_L, so a following start begins at address 0.

States:
- IDLE: busy=0, ren=0. On start=1 go to RUN and clear issue_cnt and out_cnt.
- RUN: busy=1. When issue_cnt reaches NWORDS, go to DRAIN.
- DRAIN: busy=1, ren=0. When the word with out_cnt=NWORDS-1 transfers, go to IDLE. done=1 for exactly the next cycle; busy drops in the same cycle done rises.

Read issue and buffering:
- Internal 2-entry FIFO buffers rd_data. An inflight flag equals the registered ren.
- ren=1 iff state=RUN, issue_cnt<NWORDS, and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready this cycle.
- Each ren increments issue_cnt.
- When inflight=1, rd_data is written into the FIFO at the clock edge.
- Simultaneous push and pop keeps the count unchanged. Overflow is impossible by construction; the bench asserts it.

Output side:
- m_valid = FIFO not empty. m_data = FIFO head, registered (no combinational path from rd_data).
- m_data and m_last stay stable while m_valid=1 and m_ready=0.
- out_cnt increments per transfer. m_last = m_valid & (out_cnt == NWORDS-1).

Throughput and latency:
- With m_ready held at 1: 1 word per cycle.
- First m_valid is 3 cycles after the start cycle: state change, ren, capture.
- Streaming NWORDS takes NWORDS+3 cycles, plus 1 for done.

Boundary rules:
- start during busy: no effect, no restart.
- start in the same cycle done is high: accepted.
- m_ready may toggle arbitrarily, including every cycle.
- ren never exceeds NWORDS pulses per start.

Test Plan:
1. Reset then start with m_ready=1 and a BRAM model preloaded with data=address: m_data sequence 0,1,...,4095 on consecutive cycles. m_last only on 4095. done 1 cycle after, exactly once. ren count = 4096.
2. m_ready=0 for 20 cycles after start: exactly 2 ren pulses, then ren=0. m_valid=1 with m_data=0 held stable. Releasing m_ready resumes at word 0 with no loss or duplication.
3. Random m_ready (50%, seed fixed): output equals 0..4095 in order. FIFO count never exceeds 2. Total ren = 4096.
4. Pulse start again at word 100 while busy: stream unaffected. Still a single done. ren total = 4096.
5. Assert RST_L=0 asynchronously mid-stream at word 2000: all outputs 0 within the reset. No done. A following start streams 0..4095 again from address 0.
6. Run with parameter override NWORDS=4: exactly 4 words, m_last on the 4th, done pulse. Back-to-back start in the done cycle yields a second 4-word stream.

Source files
------------

// File: rtl/matrix_stream_out_if.sv
// Handshake bundle for one macc matrix drain port: start/busy/done control,
// BRAM read side (ren/rd_data) and the valid/ready output stream.
interface matrix_stream_out_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              busy;
  logic              done;
  logic              ren;
  logic [DATA_W-1:0] rd_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport slave (
    input  start, rd_data, m_ready,
    output busy, done, ren, m_valid, m_data, m_last
  );

  modport master (
    output start, rd_data, m_ready,
    input  busy, done, ren, m_valid, m_data, m_last
  );
endinterface

// File: rtl/matrix_stream_out.sv
// Drains one macc matrix port: issues NWORDS credit-limited BRAM reads and
// replays the words on a valid/ready stream through a 2-entry FIFO.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; no reads, busy=0
//   S_RUN   | issuing reads while FIFO + in-flight word leave room
//   S_DRAIN | all reads issued; emptying FIFO until the last word leaves
module matrix_stream_out #(
  parameter int DATA_W = 32,
  parameter int NWORDS = 4096,
  parameter int CNT_W  = 13
) (
  input  logic               CLK,
  input  logic               RST_L,
  matrix_stream_out_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NWORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
  logic              done_q, done_d;
  logic              inflight_q;
  logic [DATA_W-1:0] fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q, count_d;

  logic              ren_c;
  logic              m_valid_c;
  logic              push_c;
  logic              pop_c;
  logic              last_word_c;
  logic              room_c;
  logic [2:0]        occ_c;

  assign m_valid_c   = (count_q != 2'd0);
  assign pop_c       = m_valid_c & bus.m_ready;
  assign push_c      = inflight_q;
  assign last_word_c = (out_cnt_q == CNT_LAST);

  // Words already owed to the FIFO (stored + in flight) less the one leaving now.
  assign occ_c  = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_c};
  assign room_c = (occ_c < 3'd2);

  assign count_d = count_q + {1'b0, push_c} - {1'b0, pop_c};

  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    done_d      = 1'b0;
    ren_c       = 1'b0;

    if (pop_c) begin
      out_cnt_d = out_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_RUN;
          issue_cnt_d = '0;
          out_cnt_d   = '0;
        end
      end
      S_RUN: begin
        if ((issue_cnt_q < CNT_FULL) && room_c) begin
          ren_c       = 1'b1;
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
          if (issue_cnt_q == CNT_LAST) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (pop_c && last_word_c) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q     <= S_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      done_q      <= 1'b0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      done_q      <= done_d;
      inflight_q  <= ren_c;
    end
  end

  // rd_data is only trusted on the cycle after a read enable.
  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (push_c) begin
        fifo_q[wr_ptr_q] <= bus.rd_data;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop_c) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

  assign bus.busy    = (state_q != S_IDLE);
  assign bus.done    = done_q;
  assign bus.ren     = ren_c;
  assign bus.m_valid = m_valid_c;
  assign bus.m_data  = fifo_q[rd_ptr_q];
  assign bus.m_last  = m_valid_c & last_word_c;

endmodule

// File: tb/tb_matrix_stream_out.sv
// Bench for matrix_stream_out: full-size instance checked by a stream
// scoreboard under several m_ready patterns, plus a 4-word instance run from a cycle table.
module tb_matrix_stream_out;

  localparam int DW = 32;
  localparam int N  = 4096;
  localparam int NS = 4;

  logic CLK = 1'b0;
  logic RST_L = 1'b0;
  always #5 CLK = ~CLK;

  matrix_stream_out_if #(.DATA_W(DW)) bif ();
  matrix_stream_out_if #(.DATA_W(DW)) sif ();

  matrix_stream_out #(.DATA_W(DW), .NWORDS(N), .CNT_W(13)) dut (
    .CLK(CLK), .RST_L(RST_L), .bus(bif)
  );

  matrix_stream_out #(.DATA_W(DW), .NWORDS(NS), .CNT_W(3)) dut_small (
    .CLK(CLK), .RST_L(RST_L), .bus(sif)
  );

  // BRAM models: data = address, address wraps per matrix, reset with RST_L.
  int unsigned baddr, saddr;
  always @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      baddr <= 0;
      bif.rd_data <= '0;
    end else if (bif.ren) begin
      bif.rd_data <= baddr;
      baddr <= (baddr + 1) % N;
    end else begin
      bif.rd_data <= 32'hDEAD_BEEF;
    end
  end

  always @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      saddr <= 0;
      sif.rd_data <= '0;
    end else if (sif.ren) begin
      sif.rd_data <= saddr;
      saddr <= (saddr + 1) % NS;
    end else begin
      sif.rd_data <= 32'hDEAD_BEEF;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard on the full-size instance; only this block writes the counters.
  int ren_cnt = 0, xfer_cnt = 0, done_cnt = 0, cyc = 0;
  int first_xfer = 0, last_xfer = 0;
  int base_ren = 0, base_xfer = 0, base_done = 0;

  always @(negedge CLK) begin
    cyc++;
    if (RST_L) begin
      if (bif.ren) begin
        ren_cnt++;
        chk("ren_le_nwords", 32'((ren_cnt - base_ren) <= N), 1);
      end
      if (bif.done) done_cnt++;
      if (bif.m_valid) begin
        chk("stream_data", bif.m_data, 32'(xfer_cnt - base_xfer));
        chk("stream_last", 32'(bif.m_last), 32'((xfer_cnt - base_xfer) == N - 1));
      end else begin
        chk("last_without_valid", 32'(bif.m_last), 0);
      end
      if (bif.m_valid && bif.m_ready) begin
        if (xfer_cnt == base_xfer) first_xfer = cyc;
        last_xfer = cyc;
        xfer_cnt++;
      end
      chk("outstanding_le_2",
          32'(((ren_cnt - base_ren) - (xfer_cnt - base_xfer)) <= 2), 1);
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1 bif.start = 1'b1;
    @(posedge CLK); #1 bif.start = 1'b0;
  endtask

  task automatic start_stream();
    @(posedge CLK); #1;
    base_ren  = ren_cnt;
    base_xfer = xfer_cnt;
    base_done = done_cnt;
    pulse_start();
  endtask

  task automatic wait_done(input int budget, input string name);
    int k = 0;
    while (done_cnt == base_done && k < budget) begin
      @(negedge CLK); #1;
      k++;
    end
    chk({name, "_done_seen"}, 32'(done_cnt != base_done), 1);
  endtask

  task automatic wait_xfers(input int target, input int budget, input string name);
    int k = 0;
    while ((xfer_cnt - base_xfer) < target && k < budget) begin
      @(negedge CLK); #1;
      k++;
    end
    chk({name, "_reached"}, 32'((xfer_cnt - base_xfer) >= target), 1);
  endtask

  task automatic check_stream(input string name);
    repeat (5) @(negedge CLK);
    #1;
    chk({name, "_words"}, 32'(xfer_cnt - base_xfer), N);
    chk({name, "_ren_total"}, 32'(ren_cnt - base_ren), N);
    chk({name, "_done_once"}, 32'(done_cnt - base_done), 1);
    chk({name, "_busy_idle"}, 32'(bif.busy), 0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_big"}, 32'({bif.busy, bif.done, bif.ren, bif.m_valid, bif.m_last}), 0);
    chk({name, "_big_data"}, bif.m_data, 0);
    chk({name, "_small"}, 32'({sif.busy, sif.done, sif.ren, sif.m_valid, sif.m_last}), 0);
  endtask

  typedef struct {
    logic        start;
    logic        ready;
    logic [4:0]  flags;  // {busy, ren, m_valid, m_last, done}
    logic [31:0] data;
  } vec_t;

  vec_t tbl [27];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;
    logic [4:0] act_flags;

    // NWORDS=4: two back-to-back streams at full rate, then one with early backpressure.
    tbl[0]  = '{1'b1, 1'b1, 5'b00000, 0};
    tbl[1]  = '{1'b0, 1'b1, 5'b11000, 0};
    tbl[2]  = '{1'b0, 1'b1, 5'b11000, 0};
    tbl[3]  = '{1'b0, 1'b1, 5'b11100, 0};
    tbl[4]  = '{1'b0, 1'b1, 5'b11100, 1};
    tbl[5]  = '{1'b0, 1'b1, 5'b10100, 2};
    tbl[6]  = '{1'b0, 1'b1, 5'b10110, 3};
    tbl[7]  = '{1'b1, 1'b1, 5'b00001, 0};
    tbl[8]  = '{1'b0, 1'b1, 5'b11000, 0};
    tbl[9]  = '{1'b0, 1'b1, 5'b11000, 0};
    tbl[10] = '{1'b0, 1'b1, 5'b11100, 0};
    tbl[11] = '{1'b0, 1'b1, 5'b11100, 1};
    tbl[12] = '{1'b0, 1'b1, 5'b10100, 2};
    tbl[13] = '{1'b0, 1'b1, 5'b10110, 3};
    tbl[14] = '{1'b0, 1'b1, 5'b00001, 0};
    tbl[15] = '{1'b0, 1'b1, 5'b00000, 0};
    tbl[16] = '{1'b1, 1'b0, 5'b00000, 0};
    tbl[17] = '{1'b0, 1'b0, 5'b11000, 0};
    tbl[18] = '{1'b0, 1'b0, 5'b11000, 0};
    tbl[19] = '{1'b0, 1'b0, 5'b10100, 0};
    tbl[20] = '{1'b0, 1'b0, 5'b10100, 0};
    tbl[21] = '{1'b0, 1'b1, 5'b11100, 0};
    tbl[22] = '{1'b0, 1'b1, 5'b11100, 1};
    tbl[23] = '{1'b0, 1'b1, 5'b10100, 2};
    tbl[24] = '{1'b0, 1'b1, 5'b10110, 3};
    tbl[25] = '{1'b0, 1'b1, 5'b00001, 0};
    tbl[26] = '{1'b0, 1'b1, 5'b00000, 0};

    bif.start = 1'b0;
    bif.m_ready = 1'b0;
    sif.start = 1'b0;
    sif.m_ready = 1'b0;

    repeat (3) @(posedge CLK);
    #1 check_reset_outputs("reset_state");
    @(negedge CLK); #2 RST_L = 1'b1;

    // full-rate stream
    bif.m_ready = 1'b1;
    start_stream();
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge CLK);
      if (bif.m_valid) begin
        lat = i;
        break;
      end
    end
    chk("first_valid_latency", 32'(lat), 3);
    wait_done(N + 100, "t1");
    chk("t1_throughput", 32'(last_xfer - first_xfer), N - 1);
    check_stream("t1");

    // held backpressure: two reads, then wait for credit
    bif.m_ready = 1'b0;
    start_stream();
    repeat (20) @(negedge CLK);
    #1;
    chk("t2_ren_pulses", 32'(ren_cnt - base_ren), 2);
    chk("t2_ren_low", 32'(bif.ren), 0);
    chk("t2_valid_held", 32'(bif.m_valid), 1);
    chk("t2_data_held", bif.m_data, 0);
    @(posedge CLK); #1 bif.m_ready = 1'b1;
    wait_done(N + 100, "t2");
    check_stream("t2");

    // random m_ready
    void'($urandom(32'd20240521));
    start_stream();
    seen = 1'b0;
    for (int k = 0; k < 4 * N; k++) begin
      @(posedge CLK); #1 bif.m_ready = 1'($urandom_range(0, 1));
      if (done_cnt != base_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t3_done_seen", 32'(seen), 1);
    bif.m_ready = 1'b1;
    check_stream("t3");

    // start while busy is ignored
    start_stream();
    wait_xfers(100, 200, "t4_word100");
    pulse_start();
    wait_done(N + 100, "t4");
    check_stream("t4");

    // async reset mid-stream, then a clean restart from address 0
    start_stream();
    wait_xfers(2000, 2100, "t5_word2000");
    @(posedge CLK); #3 RST_L = 1'b0;
    #1 check_reset_outputs("t5_async_reset");
    repeat (3) @(negedge CLK);
    #1;
    chk("t5_no_done", 32'(done_cnt - base_done), 0);
    check_reset_outputs("t5_held_reset");
    @(negedge CLK); #2 RST_L = 1'b1;
    repeat (2) @(negedge CLK);
    #1 chk("t5_idle_after_reset", 32'(bif.busy), 0);
    start_stream();
    wait_done(N + 100, "t5");
    check_stream("t5");

    // 4-word instance, cycle by cycle
    for (int i = 0; i < 27; i++) begin
      @(posedge CLK); #1;
      sif.start = tbl[i].start;
      sif.m_ready = tbl[i].ready;
      @(negedge CLK);
      act_flags = {sif.busy, sif.ren, sif.m_valid, sif.m_last, sif.done};
      chk($sformatf("tbl%0d_flags", i), 32'(act_flags), 32'(tbl[i].flags));
      if (tbl[i].flags[2]) begin
        chk($sformatf("tbl%0d_data", i), sif.m_data, tbl[i].data);
      end
    end
    @(posedge CLK); #1 sif.start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
